instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the 4-bit core. It owns the 9-bit program counter and drives the program-flash address bus. It returns one 12-bit instruction word per handshake and presents it, held stable, to the decode/execute stage, which consumes it via a valid/ready pair. It supports jump redirects from execute and a halt request.

## Interface
Parameters:
- ADDR_W, 9, program counter / flash address width
- INSTR_W, 12, instruction word width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- mem_addr  out  ADDR_W  flash address, always equal to pc
- mem_req  out  1  fetch request, high exactly when state is FETCH
- mem_ack  in  1  flash returns data this cycle; meaningful only while mem_req is high
- mem_rdata  in  INSTR_W  instruction word, valid in the mem_ack cycle
- instr  out  INSTR_W  instruction register to decode
- instr_valid  out  1  instr holds an unconsumed instruction
- instr_ready  in  1  decode consumes instr this cycle
- jump_en  in  1  redirect request from execute
- jump_addr  in  ADDR_W  redirect target
- halt  in  1  level request to stop fetching
- pc  out  ADDR_W  address of the next word to fetch

## Operation
- States: FETCH, HOLD, HALT.
- Reset (rst_n low at an edge):
  - state=FETCH, pc=RESET_PC, instr=0, instr_valid=0.
  - mem_req is low while rst_n is low.
- FETCH:
  - mem_req=1, instr_valid=0.
  - On mem_ack: instr<=mem_rdata, pc<=pc+1, instr_valid<=1, go to HOLD.
  - With no ack: stay in FETCH. If halt is also high, go to HALT.
- HOLD:
  - mem_req=0, instr_valid=1, instr stable.
  - On instr_ready: instr_valid<=0. Go to HALT if halt is high, otherwise go to FETCH.
  - With no instr_ready: hold indefinitely.
- HALT:
  - mem_req=0, instr_valid=0, pc held.
  - Return to FETCH in the cycle after halt is sampled low.
- jump_en has priority over everything else, in every state:
  - pc<=jump_addr.
  - FETCH: any same-cycle mem_ack data is discarded (instr unchanged). Stay in FETCH.
  - HOLD: the held instruction is squashed (instr_valid<=0), even if instr_ready is high that cycle. Go to FETCH.
  - HALT: pc is updated and the block stays in HALT.
- Priority: rst_n > jump_en > mem_ack/instr_ready > halt.
- PC arithmetic is modulo 2^ADDR_W: 511+1 wraps to 0, with no flag.
- Memory contract: the request is abortable. mem_addr may change between cycles without an ack, and flash holds no state for unacked requests.

## Timing
- mem_req and instr_valid are decoded from the registered state. They have no combinational path from any input.
- Ack-to-valid latency: instr_valid rises on the edge that samples mem_ack.
- Sustained throughput is at most 1 instruction per 2 cycles (FETCH, then HOLD), with the ack and ready each given in their first cycle.
- pc increments on the ack edge, so during HOLD pc already points at the following word.
- halt is a level and is not latched. A one-cycle halt pulse during HOLD has effect only if it coincides with instr_ready.
- instr retains its last value after consumption, squash, or halt. Only reset clears it.
- Reset mid-operation, in any state, takes effect on that edge. A pending instruction is dropped and no partial fetch survives.

## Test plan
- Reset release, flash acks every request, instr_ready tied high:
  - mem_addr sequence 0,1,2,3.
  - instr_valid pulses every 2nd cycle.
  - instr equals the programmed words in order.
- Backpressure: hold instr_ready low for 5 cycles while in HOLD.
  - instr and instr_valid stay stable.
  - mem_req stays low and pc stays at 1.
  - Raising instr_ready gives one consume, then fetch of address 1.
- Jump during HOLD with instr_ready high, jump_addr=0x1A0:
  - instr_valid falls and the instruction is not consumed.
  - Next mem_addr is 0x1A0.
- Jump coinciding with mem_ack in FETCH, jump_addr=0x005:
  - instr is unchanged and instr_valid stays 0.
  - Next request is at 0x005 and its data appears on instr.
- Wrap-around and halt:
  - Jump to 0x1FF, ack, consume: pc reads 0x000.
  - Assert halt with the next instr_ready: enter HALT, mem_req stays 0 for 4 cycles.
  - Deassert halt: next request at 0x000.
- Reset mid-HOLD: assert rst_n low with instr_valid=1.
  - Next cycle instr_valid=0, instr=0, pc=RESET_PC, mem_req=0.
  - After release: mem_req=1, mem_addr=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, issues abortable flash
// requests and holds one fetched word for decode behind a valid/ready pair.
module instr_fetch #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned INSTR_W  = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic               o_mem_req,
    input  logic               i_mem_ack,
    input  logic [INSTR_W-1:0] i_mem_rdata,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    input  logic               i_jump_en,
    input  logic [ADDR_W-1:0]  i_jump_addr,
    input  logic               i_halt,
    output logic [ADDR_W-1:0]  o_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic               r_in_rst;
    logic               w_req;
    logic               w_ack;

    // r_in_rst keeps the request low for the cycle(s) following a reset edge,
    // so mem_req stays a pure function of registered state.
    assign w_req = (r_state == S_FETCH) && !r_in_rst;
    assign w_ack = i_mem_ack && w_req;

    assign o_mem_req     = w_req;
    assign o_mem_addr    = r_pc;
    assign o_pc          = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = (r_state == S_HOLD);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        case (r_state)
            S_FETCH: begin
                if (i_jump_en) begin
                    w_pc_nxt = i_jump_addr;
                end else if (w_ack) begin
                    w_instr_nxt = i_mem_rdata;
                    w_pc_nxt    = r_pc + ADDR_W'(1);
                    w_state_nxt = S_HOLD;
                end else if (i_halt) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HOLD: begin
                // A jump squashes the held word even when decode is ready.
                if (i_jump_en) begin
                    w_pc_nxt    = i_jump_addr;
                    w_state_nxt = S_FETCH;
                end else if (i_instr_ready) begin
                    w_state_nxt = i_halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (i_jump_en) begin
                    w_pc_nxt = i_jump_addr;
                end else if (!i_halt) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_pc     <= ADDR_W'(RESET_PC);
            r_instr  <= '0;
            r_in_rst <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_in_rst <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle-by-cycle vector table with
// hand-computed outputs, plus a hand-written backpressure sequence.
module tb_instr_fetch;

    localparam int ADDR_W  = 9;
    localparam int INSTR_W = 12;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_req;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic               jump_en;
    logic [ADDR_W-1:0]  jump_addr;
    logic               halt;
    logic [ADDR_W-1:0]  pc;

    int n_vec  = 0;
    int n_fail = 0;

    instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_mem_addr   (mem_addr),
        .o_mem_req    (mem_req),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata),
        .o_instr      (instr),
        .o_instr_valid(instr_valid),
        .i_instr_ready(instr_ready),
        .i_jump_en    (jump_en),
        .i_jump_addr  (jump_addr),
        .i_halt       (halt),
        .o_pc         (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               rst_n;
        logic               ack;
        logic [INSTR_W-1:0] rdata;
        logic               ready;
        logic               jen;
        logic [ADDR_W-1:0]  jaddr;
        logic               halt;
        logic               e_req;
        logic [ADDR_W-1:0]  e_addr;
        logic               e_vld;
        logic [INSTR_W-1:0] e_instr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic a, logic [INSTR_W-1:0] d, logic rd,
                                logic j, logic [ADDR_W-1:0] ja, logic h,
                                logic eq, logic [ADDR_W-1:0] ea, logic ev,
                                logic [INSTR_W-1:0] ei);
        vec_t v;
        v.rst_n = r;  v.ack = a;   v.rdata = d;  v.ready = rd;
        v.jen   = j;  v.jaddr = ja; v.halt = h;
        v.e_req = eq; v.e_addr = ea; v.e_vld = ev; v.e_instr = ei;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        rst_n       = v.rst_n;
        mem_ack     = v.ack;
        mem_rdata   = v.rdata;
        instr_ready = v.ready;
        jump_en     = v.jen;
        jump_addr   = v.jaddr;
        halt        = v.halt;
        @(posedge clk);
        #1;
        n_vec++;
        if (mem_req !== v.e_req || mem_addr !== v.e_addr || pc !== v.e_addr ||
            instr_valid !== v.e_vld || instr !== v.e_instr) begin
            n_fail++;
            $display("FAIL %s: got req=%b addr=%h pc=%h vld=%b instr=%h, want req=%b addr=%h pc=%h vld=%b instr=%h",
                     name, mem_req, mem_addr, pc, instr_valid, instr,
                     v.e_req, v.e_addr, v.e_addr, v.e_vld, v.e_instr);
        end
    endtask

    initial begin
        vec_t bp;
        //                 rst ack rdata   rdy jen jaddr   hlt  req addr    vld instr
        // reset and release
        vt.push_back(mk(0, 0, 12'h000, 0, 0, 9'h000, 0,  0, 9'h000, 0, 12'h000));
        vt.push_back(mk(0, 0, 12'h000, 0, 0, 9'h000, 0,  0, 9'h000, 0, 12'h000));
        vt.push_back(mk(1, 0, 12'h000, 1, 0, 9'h000, 0,  1, 9'h000, 0, 12'h000));
        // streaming with ack every request and ready tied high
        vt.push_back(mk(1, 1, 12'h100, 1, 0, 9'h000, 0,  0, 9'h001, 1, 12'h100));
        vt.push_back(mk(1, 0, 12'h000, 1, 0, 9'h000, 0,  1, 9'h001, 0, 12'h100));
        vt.push_back(mk(1, 1, 12'h101, 1, 0, 9'h000, 0,  0, 9'h002, 1, 12'h101));
        vt.push_back(mk(1, 0, 12'h000, 1, 0, 9'h000, 0,  1, 9'h002, 0, 12'h101));
        vt.push_back(mk(1, 1, 12'h102, 1, 0, 9'h000, 0,  0, 9'h003, 1, 12'h102));
        vt.push_back(mk(1, 0, 12'h000, 1, 0, 9'h000, 0,  1, 9'h003, 0, 12'h102));
        vt.push_back(mk(1, 1, 12'h103, 1, 0, 9'h000, 0,  0, 9'h004, 1, 12'h103));
        vt.push_back(mk(1, 0, 12'h000, 1, 0, 9'h000, 0,  1, 9'h004, 0, 12'h103));
        // reset from FETCH, then one fetch to set up backpressure
        vt.push_back(mk(0, 0, 12'h000, 0, 0, 9'h000, 0,  0, 9'h000, 0, 12'h000));
        vt.push_back(mk(1, 0, 12'h000, 0, 0, 9'h000, 0,  1, 9'h000, 0, 12'h000));
        vt.push_back(mk(1, 1, 12'h7E1, 0, 0, 9'h000, 0,  0, 9'h001, 1, 12'h7E1));
        // index 14: consume after backpressure, fetch address 1
        vt.push_back(mk(1, 0, 12'h000, 1, 0, 9'h000, 0,  1, 9'h001, 0, 12'h7E1));
        vt.push_back(mk(1, 1, 12'h222, 0, 0, 9'h000, 0,  0, 9'h002, 1, 12'h222));
        // jump in HOLD with ready high squashes
        vt.push_back(mk(1, 0, 12'h000, 1, 1, 9'h1A0, 0,  1, 9'h1A0, 0, 12'h222));
        // jump coinciding with ack discards the data
        vt.push_back(mk(1, 1, 12'h333, 0, 1, 9'h005, 0,  1, 9'h005, 0, 12'h222));
        vt.push_back(mk(1, 1, 12'h444, 0, 0, 9'h000, 0,  0, 9'h006, 1, 12'h444));
        vt.push_back(mk(1, 0, 12'h000, 1, 0, 9'h000, 0,  1, 9'h006, 0, 12'h444));
        // wrap-around and halt
        vt.push_back(mk(1, 0, 12'h000, 0, 1, 9'h1FF, 0,  1, 9'h1FF, 0, 12'h444));
        vt.push_back(mk(1, 1, 12'h555, 0, 0, 9'h000, 0,  0, 9'h000, 1, 12'h555));
        vt.push_back(mk(1, 0, 12'h000, 1, 0, 9'h000, 1,  0, 9'h000, 0, 12'h555));
        vt.push_back(mk(1, 1, 12'hBAD, 0, 0, 9'h000, 1,  0, 9'h000, 0, 12'h555));
        vt.push_back(mk(1, 0, 12'h000, 0, 0, 9'h000, 1,  0, 9'h000, 0, 12'h555));
        vt.push_back(mk(1, 0, 12'h000, 0, 0, 9'h000, 1,  0, 9'h000, 0, 12'h555));
        // jump while halted updates pc but stays halted
        vt.push_back(mk(1, 0, 12'h000, 0, 1, 9'h0F0, 1,  0, 9'h0F0, 0, 12'h555));
        vt.push_back(mk(1, 0, 12'h000, 0, 1, 9'h000, 0,  0, 9'h000, 0, 12'h555));
        vt.push_back(mk(1, 0, 12'h000, 0, 0, 9'h000, 0,  1, 9'h000, 0, 12'h555));
        vt.push_back(mk(1, 1, 12'h666, 0, 0, 9'h000, 0,  0, 9'h001, 1, 12'h666));
        // reset mid-HOLD, then release
        vt.push_back(mk(0, 0, 12'h000, 0, 0, 9'h000, 0,  0, 9'h000, 0, 12'h000));
        vt.push_back(mk(1, 0, 12'h000, 0, 0, 9'h000, 0,  1, 9'h000, 0, 12'h000));
        // halt in FETCH without ack, then resume
        vt.push_back(mk(1, 0, 12'h000, 0, 0, 9'h000, 1,  0, 9'h000, 0, 12'h000));
        vt.push_back(mk(1, 0, 12'h000, 0, 0, 9'h000, 0,  1, 9'h000, 0, 12'h000));
        // halt pulse in HOLD without ready is ignored
        vt.push_back(mk(1, 1, 12'h777, 0, 0, 9'h000, 0,  0, 9'h001, 1, 12'h777));
        vt.push_back(mk(1, 0, 12'h000, 0, 0, 9'h000, 1,  0, 9'h001, 1, 12'h777));
        vt.push_back(mk(1, 0, 12'h000, 1, 0, 9'h000, 0,  1, 9'h001, 0, 12'h777));
        // ack outranks halt in FETCH
        vt.push_back(mk(1, 1, 12'h888, 0, 0, 9'h000, 1,  0, 9'h002, 1, 12'h888));

        for (int i = 0; i < 14; i++) apply(vt[i], $sformatf("vec%0d", i));

        // backpressure: five cycles with ready low, spurious ack on the bus
        bp = mk(1, 1, 12'hFFF, 0, 0, 9'h000, 0,  0, 9'h001, 1, 12'h7E1);
        for (int k = 0; k < 5; k++) apply(bp, $sformatf("backpressure%0d", k));

        for (int i = 14; i < vt.size(); i++) apply(vt[i], $sformatf("vec%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
